// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense scheduler.
// Contents: FSM state enum, hopper coin values, item encoding, greedy coin pick.
// FAULT state exists only when VEND_TIMEOUT_EN is defined.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VEND,
        PAY,
        GAP,
        DONE
`ifdef VEND_TIMEOUT_EN
        , FAULT
`endif
    } state_t;

    localparam logic [2:0] COIN5 = 3'd5;
    localparam logic [2:0] COIN2 = 3'd2;
    localparam logic [2:0] COIN1 = 3'd1;

    localparam logic ITEM_CHOC  = 1'b1;
    localparam logic ITEM_DRINK = 1'b0;

    // Largest hopper coin that does not exceed the remaining change.
    function automatic logic [2:0] coin_for(input logic [2:0] rem);
        if (rem >= COIN5)      return COIN5;
        else if (rem >= COIN2) return COIN2;
        else                   return COIN1;
    endfunction

    // Same choice as coin_for, as {coin5, coin2, coin1} drive bits.
    function automatic logic [2:0] coin_drive(input logic [2:0] rem);
        if (rem >= COIN5)      return 3'b100;
        else if (rem >= COIN2) return 3'b010;
        else                   return 3'b001;
    endfunction

endpackage

// File: rtl/vend_rr_arb.sv
// Round-robin arbiter: picks the first active request after the last winner.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to sample the result.
// Ports: req (requests), last (previous winner index) -> win_oh (one-hot), win_idx.
module vend_rr_arb #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]                 req,
    input  logic [((NREQ > 2) ? 2 : 1)-1:0] last,
    output logic [NREQ-1:0]                 win_oh,
    output logic [((NREQ > 2) ? 2 : 1)-1:0] win_idx
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    int k;

    // Walk from lowest to highest priority so the highest-priority
    // (closest after last) active request is the final overwrite.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        k       = 0;
        for (int i = NREQ; i >= 1; i--) begin
            k = (int'(last) + i) % NREQ;
            if (req[k]) begin
                win_oh    = '0;
                win_oh[k] = 1'b1;
                win_idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/vend_dispense_sched.sv
// Dispense scheduler: round-robin grants sales, runs the motor, pays greedy 5/2/1 change.
// Latency: gnt/motor 1 cycle after req in IDLE; each coin 2*PULSE_W cycles; done 1 cycle.
// Backpressure: req held until gnt; others ignored until the block is back in IDLE.
// Ports: clk, rst (async active-low), req/req_item/req_change in, gnt/done/err/busy out,
//        motor_choc/motor_drink out, vend_sense in, coin5/coin2/coin1 out.
// Option: VEND_TIMEOUT_EN adds a MOTOR_TO-cycle motor timeout with FAULT state and err.
module vend_dispense_sched
    import vend_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int PULSE_W  = 4,
    parameter int MOTOR_TO = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_item,
    input  logic [3*NREQ-1:0] req_change,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic              busy,
    output logic              motor_choc,
    output logic              motor_drink,
    input  logic              vend_sense,
    output logic              coin5,
    output logic              coin2,
    output logic              coin1
);

    localparam int         IW      = (NREQ > 2) ? 2 : 1;
    localparam logic [3:0] PW_LAST = 4'(PULSE_W - 1);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] win_oh;
    logic [2:0]      rem;
    logic [3:0]      cnt;

    logic [NREQ-1:0] arb_oh;
    logic [IW-1:0]   arb_idx;

`ifdef VEND_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(MOTOR_TO - 1);
    logic [7:0] tcnt;
`endif

    vend_rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .last    (ptr),
        .win_oh  (arb_oh),
        .win_idx (arb_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= IW'(NREQ - 1);
            win_oh      <= '0;
            rem         <= '0;
            cnt         <= '0;
            gnt         <= '0;
            done        <= '0;
            busy        <= 1'b0;
            motor_choc  <= 1'b0;
            motor_drink <= 1'b0;
            {coin5, coin2, coin1} <= 3'b000;
`ifdef VEND_TIMEOUT_EN
            tcnt        <= '0;
            err         <= 1'b0;
`endif
        end else begin
            // gnt, done and err are single-cycle pulses
            gnt  <= '0;
            done <= '0;
`ifdef VEND_TIMEOUT_EN
            err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        win_oh      <= arb_oh;
                        ptr         <= arb_idx;
                        rem         <= req_change[3*arb_idx +: 3];
                        motor_choc  <= (req_item[arb_idx] == ITEM_CHOC);
                        motor_drink <= (req_item[arb_idx] == ITEM_DRINK);
                        gnt         <= arb_oh;
                        busy        <= 1'b1;
                        cnt         <= '0;
`ifdef VEND_TIMEOUT_EN
                        tcnt        <= '0;
`endif
                        state       <= VEND;
                    end
                end
                VEND: begin
                    if (vend_sense) begin
                        motor_choc  <= 1'b0;
                        motor_drink <= 1'b0;
                        cnt         <= '0;
                        if (rem == 3'd0) begin
                            done  <= win_oh;
                            state <= DONE;
                        end else begin
                            {coin5, coin2, coin1} <= coin_drive(rem);
                            state <= PAY;
                        end
                    end
`ifdef VEND_TIMEOUT_EN
                    else if (tcnt == TO_LAST) begin
                        motor_choc  <= 1'b0;
                        motor_drink <= 1'b0;
                        err         <= 1'b1;
                        done        <= win_oh;
                        state       <= FAULT;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
`endif
                end
                PAY: begin
                    // coin stays fixed for the whole pulse; rem settles on its last cycle
                    if (cnt == PW_LAST) begin
                        {coin5, coin2, coin1} <= 3'b000;
                        rem   <= rem - coin_for(rem);
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == PW_LAST) begin
                        cnt <= '0;
                        if (rem != 3'd0) begin
                            {coin5, coin2, coin1} <= coin_drive(rem);
                            state <= PAY;
                        end else begin
                            done  <= win_oh;
                            state <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
`ifdef VEND_TIMEOUT_EN
                FAULT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef VEND_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vend_dispense_sched.sv
// Directed bench for vend_dispense_sched (NREQ=2, PULSE_W=4, MOTOR_TO=10).
// Every cycle of each sale is compared against a hand-built expected output vector.
// Observed vector layout: {gnt[1:0], done[1:0], err, busy, motor_choc, motor_drink, coin5, coin2, coin1}.
module tb_vend_dispense_sched;

    localparam int NREQ = 2;
    localparam int PW   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  req_item = '0;
    logic [5:0]  req_change = '0;
    logic        vend_sense = 1'b0;
    logic [1:0]  gnt, done;
    logic        err, busy, motor_choc, motor_drink, coin5, coin2, coin1;
    logic [10:0] obs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vend_dispense_sched #(.NREQ(NREQ), .PULSE_W(PW), .MOTOR_TO(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_item    (req_item),
        .req_change  (req_change),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .motor_choc  (motor_choc),
        .motor_drink (motor_drink),
        .vend_sense  (vend_sense),
        .coin5       (coin5),
        .coin2       (coin2),
        .coin1       (coin1)
    );

    assign obs = {gnt, done, err, busy, motor_choc, motor_drink, coin5, coin2, coin1};

    function automatic logic [10:0] mk(input logic [1:0] g, input logic [1:0] d,
                                       input logic e, b, mc, md, c5, c2, c1);
        return {g, d, e, b, mc, md, c5, c2, c1};
    endfunction

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered 1ns after a posedge; leaves 1ns after a later posedge, block idle.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("reset_async", obs, 11'b0);
        tick();
        tick();
        chk("reset_hold", obs, 11'b0);
        #2;
        rst = 1'b1;
        tick();
        chk("reset_idle", obs, 11'b0);
    endtask

    // One complete sale for requester idx; 'held' requests stay asserted throughout.
    task automatic sale(input logic [1:0] held, input int idx, input logic item,
                        input logic [2:0] change, input int vend_cyc, input logic noisy);
        logic [1:0] oh;
        logic [2:0] rem;
        int         c;
        oh = 2'b01 << idx;
        req = held | oh;
        req_item[idx] = item;
        req_change[3*idx +: 3] = change;
        tick();
        req = held;
        for (int m = 1; m <= vend_cyc; m++) begin
            chk("vend", obs, mk((m == 1) ? oh : 2'b00, 2'b00, 1'b0, 1'b1, item, !item, 1'b0, 1'b0, 1'b0));
            vend_sense = (m == vend_cyc);
            tick();
        end
        vend_sense = 1'b0;
        rem = change;
        while (rem != 3'd0) begin
            c = (rem >= 3'd5) ? 5 : (rem >= 3'd2) ? 2 : 1;
            for (int p = 0; p < PW; p++) begin
                chk("coin", obs, mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, c == 5, c == 2, c == 1));
                vend_sense = noisy;
                tick();
            end
            for (int p = 0; p < PW; p++) begin
                chk("gap", obs, mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                vend_sense = noisy;
                tick();
            end
            rem = rem - 3'(c);
        end
        vend_sense = 1'b0;
        chk("done", obs, mk(2'b00, oh, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        chk("idle", obs, mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        #1;
        do_reset();

        // chocolate, no change, motor on for 3 cycles
        sale(2'b00, 0, 1'b1, 3'd0, 3, 1'b0);
        // drink, change 7 -> coin5 then coin2
        sale(2'b00, 0, 1'b0, 3'd7, 2, 1'b0);
        // change 4 -> coin2 twice, vend_sense stuck high outside VEND must be ignored
        sale(2'b00, 0, 1'b1, 3'd4, 1, 1'b1);
        // change 1 -> one coin1
        sale(2'b00, 0, 1'b0, 3'd1, 4, 1'b0);

`ifdef VEND_TIMEOUT_EN
        // motor timeout: 10 motor cycles, then err+done together, no coins
        req = 2'b01;
        req_item[0] = 1'b1;
        req_change[2:0] = 3'd3;
        tick();
        req = 2'b00;
        for (int m = 1; m <= 10; m++) begin
            chk("to_vend", obs, mk((m == 1) ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
            tick();
        end
        chk("to_fault", obs, mk(2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        chk("to_idle", obs, 11'b0);
`else
        // no timeout: motor stays on well past 255 cycles
        sale(2'b00, 0, 1'b0, 3'd0, 300, 1'b0);
`endif

        // both requesters after reset: 0 first, then alternation 1,0,1
        do_reset();
        sale(2'b10, 0, 1'b1, 3'd0, 2, 1'b0);
        sale(2'b01, 1, 1'b0, 3'd2, 1, 1'b0);
        sale(2'b10, 0, 1'b0, 3'd5, 2, 1'b0);
        sale(2'b00, 1, 1'b1, 3'd3, 3, 1'b0);

        // reset during the second coin of a change=7 sale
        req = 2'b01;
        req_item[0] = 1'b0;
        req_change[2:0] = 3'd7;
        tick();
        chk("abort_gnt", obs, mk(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        req = 2'b00;
        vend_sense = 1'b1;
        tick();
        vend_sense = 1'b0;
        chk("abort_coin5", obs, mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 2*PW; i++) tick();
        chk("abort_coin2", obs, mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        #2;
        do_reset();
        tick();
        chk("abort_no_done", obs, 11'b0);
        // clean sale afterwards, requester 0 wins first again
        sale(2'b00, 0, 1'b1, 3'd6, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
